// File: rtl/uart_pkg.sv
// Shared UART definitions: the byte width, the receiver/transmitter state
// encodings and small helpers used by both directions.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // Two-of-three vote used to filter each mid-bit sample window.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with a combinational head output; pointers carry
// one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, majority-vote bit sampling FSM, framing
// and break detection, feeding a small receive FIFO with overrun flag.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 416,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk48,
   input  logic              rst,
   input  logic              rx_serial,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              frame_err,
   output logic              break_det,
   output logic              overrun
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
   localparam logic [CW-1:0] C_S1   = CW'(HALF);
   localparam logic [CW-1:0] C_S2   = CW'(HALF + 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   rx_state_e         state_q;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        bit_q;
   logic [DATA_W-1:0] shreg_q;
   logic [1:0]        samp_q;
   logic              sync1_q, rxs_q;
   logic              frame_err_q, break_q, overrun_q, overrun_d;

   logic              decide;
   logic              bit_val;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_dout;

   // rx_serial is asynchronous; nothing past rxs_q looks at it directly.
   always_ff @(posedge clk48) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= rx_serial;
         rxs_q   <= sync1_q;
      end
   end

   assign decide  = ((state_q == RX_START) || (state_q == RX_DATA) ||
                     (state_q == RX_STOP)) && (cnt_q == C_S2);
   assign bit_val = maj3(samp_q[0], samp_q[1], rxs_q);

   always_ff @(posedge clk48) begin
      if (cnt_q == C_S0) samp_q[0] <= rxs_q;
      if (cnt_q == C_S1) samp_q[1] <= rxs_q;
      if ((state_q == RX_DATA) && decide) shreg_q <= {bit_val, shreg_q[DATA_W-1:1]};
   end

   always_ff @(posedge clk48) begin
      if (rst) begin
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         frame_err_q <= 1'b0;
         break_q     <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         break_q     <= 1'b0;
         if ((state_q == RX_IDLE) || (state_q == RX_WAIT_HIGH) || (cnt_q == C_LAST))
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + C_ONE;

         case (state_q)
            RX_IDLE: begin
               if (!rxs_q) state_q <= RX_START;
            end
            RX_START: begin
               bit_q <= '0;
               if (decide) state_q <= bit_val ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
               if (decide) begin
                  bit_q <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (decide) begin
                  if (bit_val) begin
                     state_q <= RX_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     break_q     <= (shreg_q == '0);
                     state_q     <= RX_WAIT_HIGH;
                  end
               end
            end
            RX_WAIT_HIGH: begin
               if (rxs_q) state_q <= RX_IDLE;
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   // The push is issued in the decision cycle so the byte is visible one cycle later.
   assign fifo_push = (state_q == RX_STOP) && decide && bit_val;
   assign fifo_pop  = rx_valid && rx_ready;

   uart_rx_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk48),
      .rst_i   (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (shreg_q),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      overrun_d = overrun_q;
      if (fifo_push && fifo_full && !fifo_pop) overrun_d = 1'b1;
      else if (fifo_pop)                       overrun_d = 1'b0;
   end

   always_ff @(posedge clk48) begin
      if (rst) overrun_q <= 1'b0;
      else     overrun_q <= overrun_d;
   end

   assign rx_valid  = !fifo_empty;
   assign rx_data   = rx_valid ? fifo_dout : '0;
   assign busy      = (state_q != RX_IDLE);
   assign frame_err = frame_err_q;
   assign break_det = break_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk48 = 1'b0;
   logic       rst = 1'b1;
   logic       rx_serial = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, busy, frame_err, break_det, overrun;

   uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk48     (clk48),
      .rst       (rst),
      .rx_serial (rx_serial),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .busy      (busy),
      .frame_err (frame_err),
      .break_det (break_det),
      .overrun   (overrun)
   );

   always #5 clk48 = ~clk48;

   int         n_tot = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         fe_n = 0;
   int         brk_n = 0;
   int         busy_run = 0;
   int         last_busy_run = 0;
   int         rise_cyc = 0;
   int         start_cyc = 0;
   logic [7:0] pop_n = 8'd0;
   logic [7:0] pop_log [256];
   logic       valid_prev = 1'b0;

   always @(posedge clk48) cyc <= cyc + 1;

   // Event recorder: pulse counts, popped bytes, busy run lengths.
   always @(negedge clk48) begin
      if (frame_err) fe_n <= fe_n + 1;
      if (break_det) brk_n <= brk_n + 1;
      if (rx_valid && rx_ready) begin
         pop_log[pop_n] <= rx_data;
         pop_n <= pop_n + 8'd1;
      end
      if (rx_valid && !valid_prev) rise_cyc <= cyc;
      valid_prev <= rx_valid;
      if (busy) busy_run <= busy_run + 1;
      else begin
         if (busy_run != 0) last_busy_run <= busy_run;
         busy_run <= 0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk48);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      rx_serial = 1'b0;
      start_cyc = cyc;
      step(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_serial = d[i];
         step(CPB);
      end
      rx_serial = stop;
      step(CPB);
      rx_serial = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         fe;
      int         brk;
      int         pops;
   } vec_t;

   vec_t       vecs [7];
   int         fe0, brk0;
   logic [7:0] pb, idx;

   initial begin
      vecs[0] = '{8'h5A, 1'b1, 0, 0, 1};
      vecs[1] = '{8'h3C, 1'b0, 1, 0, 0};
      vecs[2] = '{8'h11, 1'b1, 0, 0, 1};
      vecs[3] = '{8'h00, 1'b1, 0, 0, 1};
      vecs[4] = '{8'h00, 1'b0, 1, 1, 0};
      vecs[5] = '{8'hC3, 1'b1, 0, 0, 1};
      vecs[6] = '{8'hFF, 1'b1, 0, 0, 1};

      // reset state
      step(4);
      @(negedge clk48);
      chk("rst_valid", rx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_fe", frame_err, 0);
      chk("rst_brk", break_det, 0);
      @(posedge clk48); #1;
      rst = 1'b0;
      step(4);

      // A5 with push latency measured from the start-bit edge
      fe0 = fe_n; brk0 = brk_n; pb = pop_n;
      send_frame(8'hA5, 1'b1);
      step(10);
      chk("a5_latency", rise_cyc - start_cyc, 157);
      chk("a5_pops", int'(pop_n - pb), 1);
      chk("a5_data", pop_log[pb], 8'hA5);
      chk("a5_valid_after", rx_valid, 0);
      chk("a5_fe", fe_n - fe0, 0);
      chk("a5_brk", brk_n - brk0, 0);

      // table of single frames, consumer always ready
      for (int i = 0; i < 7; i++) begin
         fe0 = fe_n; brk0 = brk_n; pb = pop_n;
         send_frame(vecs[i].data, vecs[i].stop);
         step(20);
         chk($sformatf("vec%0d_fe", i), fe_n - fe0, vecs[i].fe);
         chk($sformatf("vec%0d_brk", i), brk_n - brk0, vecs[i].brk);
         chk($sformatf("vec%0d_pops", i), int'(pop_n - pb), vecs[i].pops);
         if (vecs[i].pops == 1) chk($sformatf("vec%0d_data", i), pop_log[pb], vecs[i].data);
         chk($sformatf("vec%0d_idle", i), busy, 0);
      end

      // 5-cycle glitch
      fe0 = fe_n; pb = pop_n;
      rx_serial = 1'b0;
      step(5);
      rx_serial = 1'b1;
      step(20);
      chk("glitch_busy_len", int'(last_busy_run > 0 && last_busy_run <= 10), 1);
      chk("glitch_pops", int'(pop_n - pb), 0);
      chk("glitch_fe", fe_n - fe0, 0);

      // break: 12 bit times low, then 8'h55
      fe0 = fe_n; brk0 = brk_n; pb = pop_n;
      rx_serial = 1'b0;
      step(12 * CPB - 1);
      chk("brk_wait_busy", busy, 1);
      step(1);
      rx_serial = 1'b1;
      step(6);
      chk("brk_released", busy, 0);
      chk("brk_fe", fe_n - fe0, 1);
      chk("brk_brk", brk_n - brk0, 1);
      send_frame(8'h55, 1'b1);
      step(10);
      chk("brk_pops", int'(pop_n - pb), 1);
      chk("brk_next_data", pop_log[pb], 8'h55);

      // overrun: five bytes into four slots
      rx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      step(4);
      chk("ovr_flag", overrun, 1);
      chk("ovr_valid", rx_valid, 1);
      for (int i = 1; i <= 4; i++) begin
         rx_ready = 1'b1;
         @(negedge clk48);
         chk($sformatf("ovr_pop%0d", i), rx_data, i);
         @(posedge clk48); #1;
         rx_ready = 1'b0;
         if (i == 1) chk("ovr_clear", overrun, 0);
      end
      chk("ovr_empty", rx_valid, 0);

      // push and pop together on a full FIFO
      for (int i = 10; i <= 13; i++) send_frame(8'(i), 1'b1);
      fork
         send_frame(8'h0E, 1'b1);
         begin
            step(156);
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
         end
      join
      step(4);
      chk("full_pp_ovr", overrun, 0);
      pb = pop_n;
      rx_ready = 1'b1;
      step(8);
      chk("full_pp_pops", int'(pop_n - pb), 4);
      for (int j = 0; j < 4; j++) begin
         idx = pb + 8'(j);
         chk($sformatf("full_pp_data%0d", j), pop_log[idx], 11 + j);
      end

      // reset in the middle of a frame with bytes queued
      rx_ready = 1'b0;
      send_frame(8'h21, 1'b1);
      send_frame(8'h22, 1'b1);
      fe0 = fe_n;
      fork
         send_frame(8'hFF, 1'b1);
         begin
            step(88);
            rst = 1'b1;
            step(2);
            chk("mid_rst_valid", rx_valid, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_data", rx_data, 0);
            chk("mid_rst_fe", frame_err, 0);
            chk("mid_rst_brk", break_det, 0);
            chk("mid_rst_ovr", overrun, 0);
            rst = 1'b0;
         end
      join
      pb = pop_n;
      rx_ready = 1'b1;
      step(20);
      chk("mid_rst_nopush", int'(pop_n - pb), 0);
      chk("mid_rst_nofe", fe_n - fe0, 0);
      send_frame(8'h80, 1'b1);
      step(10);
      chk("after_rst_pops", int'(pop_n - pb), 1);
      chk("after_rst_data", pop_log[pb], 8'h80);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
